md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage pipeline; owns the HI/LO registers.
- It is the producer end of the MD hazard interface: it raises `busy` and `md_stall_req`.
- The hazard/stall controller consumes `md_stall_req` to freeze any D-stage MD instruction (mult/div/mfhi/mflo/mthi/mtlo).
- Results are committed to HI/LO after a fixed per-operation latency.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  E-stage instruction is an MD op (qualifies md_op).
- md_op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU.
- cancel  input  1  E-stage instruction is being killed (exception/flush); blocks acceptance this cycle.
- rs_data  input  32  operand A (forwarded rs value).
- rt_data  input  32  operand B (forwarded rt value).
- busy  output  1  multi-cycle operation in flight.
- md_stall_req  output  1  busy | (start & md_op in 1..4,7,8 & ~cancel); to stall controller.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, shadow regs=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- Accept condition, cycle T: start & ~cancel & ~busy & md_op valid.
- On accept, multi-cycle ops:
  - Result computed combinationally from rs/rt and latched into shadow_hi/shadow_lo.
  - counter <= MULT_CYCLES or DIV_CYCLES; busy=1 from cycle T+1 through T+N.
  - At the edge ending cycle T+N: hi/lo <= shadow, counter -> 0.
  - busy=0 and the new hi/lo are visible in cycle T+N+1.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo}=product.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divide by zero (rt_data=0): op still takes DIV_CYCLES; hi/lo left unchanged at commit.
  - DIV 0x80000000 / -1: lo=0x80000000, hi=0 (wrap, no trap).
- MTHI/MTLO: single cycle, no busy. On accept, hi (or lo) <= rs_data at the next edge.
- MTHI/MTLO arriving while busy: not accepted. md_stall_req is already 1 via busy, so the stall controller holds it in D; the unit also ignores it defensively.
- start with a multi-cycle op while busy: ignored; no restart and no shadow change. Bench asserts this never occurs.
- cancel & start in the same cycle: nothing accepted, no state change. md_stall_req excludes the cancelled start term.
- cancel while busy: in-flight op is NOT aborted; it completes and commits normally.
- md_op NONE or an unknown code with start=1: no effect.
- hi/lo reads (MFHI/MFLO) come directly from the registers; the stall controller guarantees none is in E while busy.

Optional Feature:
- Macro: MD_UNIT_MADD_EN.
- Defined:
  - md_op 7 MADD: {hi,lo} <= {hi,lo} + signed product.
  - md_op 8 MADDU: {hi,lo} <= {hi,lo} + unsigned product.
  - Both take MULT_CYCLES. Accumulation uses the hi/lo value present at commit time; no other writer can intervene because of busy.
- Undefined: codes 7/8 are treated as NONE (no effect, not counted in md_stall_req).

Decomposition:
- Shared package (mips_pkg):
  - md_op encodings as named constants (MD_NONE..MD_MADDU).
  - MD_OP_W=4.
  - Default cycle-count constants.
- One sub-module, md_seq_ctrl: counter load/decrement, busy, commit strobe. Arithmetic and HI/LO registers stay in md_unit.

Test Plan:
- MULT rs=0xFFFFFFFE (-2), rt=3 at T -> busy=1 for T+1..T+5; cycle T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- DIVU rs=100, rt=7 -> busy 10 cycles, then lo=14, hi=2. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (one cycle each, busy stays 0); then DIV rs=5, rt=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- MULTU start with cancel=1 -> md_stall_req=0, busy=0, hi/lo unchanged. MULTU accepted, then cancel=1 at T+2 -> still commits at T+5.
- Start DIV, deassert reset_n at T+4 -> busy/hi/lo=0 immediately; after release, a new MULT 6x7 gives lo=42 after 5 cycles.
- MD_UNIT_MADD_EN: hi/lo=0/0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=1, lo=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-pipeline definitions for the multiply/divide unit:
// md_op encodings, op width and default busy-cycle counts.
// Optional feature macro: MD_UNIT_MADD_EN (adds MADD/MADDU as multi-cycle ops).
package mips_pkg;

  localparam int MD_OP_W  = 4;
  localparam int MD_CNT_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_RUN
  } md_seq_state_e;

  // True for ops that occupy the unit for several cycles (and so raise a stall).
  function automatic logic md_is_multi(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
      MD_MADD, MD_MADDU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage <-> multiply/divide unit bundle: request side from the pipeline,
// HI/LO and hazard signals back from the unit.
interface md_unit_if;
  import mips_pkg::*;

  logic               start;
  logic [MD_OP_W-1:0] md_op;
  logic               cancel;
  logic [31:0]        rs_data;
  logic [31:0]        rt_data;
  logic               busy;
  logic               md_stall_req;
  logic [31:0]        hi;
  logic [31:0]        lo;

  modport master (
    output start, md_op, cancel, rs_data, rt_data,
    input  busy, md_stall_req, hi, lo
  );

  modport slave (
    input  start, md_op, cancel, rs_data, rt_data,
    output busy, md_stall_req, hi, lo
  );
endinterface

// File: rtl/md_seq_ctrl.sv
// Busy-cycle sequencer for md_unit: loads a cycle count on accept, counts
// down while busy and pulses commit in the last busy cycle.
module md_seq_ctrl
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_cycles,
  output logic                busy,
  output logic                commit
);

  md_seq_state_e       state_reg, state_next;
  logic [MD_CNT_W-1:0] cnt_reg, cnt_next;

  // State and remaining-cycle register; reset discards any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= SEQ_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state, countdown and commit strobe (commit on the final busy cycle).
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy       = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      SEQ_IDLE: begin
        if (load) begin
          state_next = SEQ_RUN;
          cnt_next   = load_cycles;
        end
      end
      SEQ_RUN: begin
        busy = 1'b1;
        if (cnt_reg <= MD_CNT_W'(1)) begin
          commit     = 1'b1;
          state_next = SEQ_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - MD_CNT_W'(1);
        end
      end
      default: begin
        state_next = SEQ_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit (E stage) owning HI/LO.
// Result is computed at accept, held in shadow registers and committed to
// HI/LO after MULT_CYCLES / DIV_CYCLES. Divide by zero leaves HI/LO alone.
// Optional feature macro: MD_UNIT_MADD_EN (MADD/MADDU accumulate into HI/LO).
module md_unit
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  md_unit_if.slave md
);

  logic        busy, commit, accept, is_multi, load, is_div;
  logic [63:0] res_next;
  logic        wr_next, acc_next;
  logic [31:0] hi_reg, lo_reg, shadow_hi_reg, shadow_lo_reg;
  logic        shadow_wr_reg, shadow_acc_reg;

  assign is_multi        = md_is_multi(md.md_op);
  assign accept          = md.start & ~md.cancel & ~busy;
  assign load            = accept & is_multi;
  assign md.busy         = busy;
  assign md.md_stall_req = busy | (md.start & is_multi & ~md.cancel);
  assign md.hi           = hi_reg;
  assign md.lo           = lo_reg;

  md_seq_ctrl u_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_cycles (is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES)),
    .busy        (busy),
    .commit      (commit)
  );

  // Products and quotients; signed divide works on magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, b_mag_safe, q_mag, r_mag, q_s, r_s;
  logic [31:0]        rt_safe, q_u, r_u;

  assign prod_s     = $signed({{32{md.rs_data[31]}}, md.rs_data}) *
                      $signed({{32{md.rt_data[31]}}, md.rt_data});
  assign prod_u     = {32'd0, md.rs_data} * {32'd0, md.rt_data};
  assign a_mag      = md.rs_data[31] ? (~md.rs_data + 32'd1) : md.rs_data;
  assign b_mag      = md.rt_data[31] ? (~md.rt_data + 32'd1) : md.rt_data;
  assign b_mag_safe = (md.rt_data == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign q_s        = (md.rs_data[31] ^ md.rt_data[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s        = md.rs_data[31] ? (~r_mag + 32'd1) : r_mag;
  assign rt_safe    = (md.rt_data == 32'd0) ? 32'd1 : md.rt_data;
  assign q_u        = md.rs_data / rt_safe;
  assign r_u        = md.rs_data % rt_safe;

  // Select the pending result and how it is to be committed.
  always_comb begin
    res_next = 64'd0;
    wr_next  = 1'b1;
    acc_next = 1'b0;
    is_div   = 1'b0;
    case (md.md_op)
      MD_MULT:  res_next = prod_s;
      MD_MULTU: res_next = prod_u;
      MD_DIV: begin
        res_next = {r_s, q_s};
        wr_next  = (md.rt_data != 32'd0);
        is_div   = 1'b1;
      end
      MD_DIVU: begin
        res_next = {r_u, q_u};
        wr_next  = (md.rt_data != 32'd0);
        is_div   = 1'b1;
      end
`ifdef MD_UNIT_MADD_EN
      MD_MADD: begin
        res_next = prod_s;
        acc_next = 1'b1;
      end
      MD_MADDU: begin
        res_next = prod_u;
        acc_next = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Shadow result captured once at accept; untouched while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_hi_reg  <= '0;
      shadow_lo_reg  <= '0;
      shadow_wr_reg  <= 1'b0;
      shadow_acc_reg <= 1'b0;
    end else if (load) begin
      shadow_hi_reg  <= res_next[63:32];
      shadow_lo_reg  <= res_next[31:0];
      shadow_wr_reg  <= wr_next;
      shadow_acc_reg <= acc_next;
    end
  end

  // Architectural HI/LO: multi-cycle commit or single-cycle MTHI/MTLO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (commit) begin
      if (shadow_wr_reg) begin
        if (shadow_acc_reg)
          {hi_reg, lo_reg} <= {hi_reg, lo_reg} + {shadow_hi_reg, shadow_lo_reg};
        else
          {hi_reg, lo_reg} <= {shadow_hi_reg, shadow_lo_reg};
      end
    end else if (accept && md.md_op == MD_MTHI) begin
      hi_reg <= md.rs_data;
    end else if (accept && md.md_op == MD_MTLO) begin
      lo_reg <= md.rs_data;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_md_unit;
  import mips_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo;
  int          m_rem;
  logic [63:0] m_res;
  logic        m_wr, m_acc;

  function automatic bit madd_on();
`ifdef MD_UNIT_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit multi(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1'b1;
    if (op == 4'd7 || op == 4'd8) return madd_on();
    return 1'b0;
  endfunction

  function automatic logic [63:0] calc_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int ia, ib, q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    ia = a;
    ib = b;
    case (op)
      4'd1, 4'd7: return sa * sb;
      4'd2, 4'd8: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return 64'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      4'd4: begin
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Model: remaining busy cycles; result applied on the last one.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi <= 0; m_lo <= 0; m_rem <= 0; m_res <= 0; m_wr <= 0; m_acc <= 0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_wr) begin
        if (m_acc) {m_hi, m_lo} <= {m_hi, m_lo} + m_res;
        else       {m_hi, m_lo} <= m_res;
      end
    end else if (bus.start && !bus.cancel) begin
      if (multi(bus.md_op)) begin
        m_rem <= (bus.md_op == 4'd3 || bus.md_op == 4'd4) ? DC : MC;
        m_res <= calc_res(bus.md_op, bus.rs_data, bus.rt_data);
        m_wr  <= !((bus.md_op == 4'd3 || bus.md_op == 4'd4) && bus.rt_data == 32'd0);
        m_acc <= (bus.md_op == 4'd7 || bus.md_op == 4'd8);
      end else if (bus.md_op == 4'd5) begin
        m_hi <= bus.rs_data;
      end else if (bus.md_op == 4'd6) begin
        m_lo <= bus.rs_data;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    check("busy", bus.busy, m_rem > 0);
    check("md_stall_req", bus.md_stall_req,
          (m_rem > 0) || (bus.start && !bus.cancel && multi(bus.md_op)));
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    check("no_restart_while_busy", bus.start && !bus.cancel && (m_rem > 0) && multi(bus.md_op), 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit s, input logic [3:0] op, input bit c,
                       input logic [31:0] a, input logic [31:0] b);
    bus.start = s; bus.md_op = op; bus.cancel = c; bus.rs_data = a; bus.rt_data = b;
  endtask

  // Present one op for one cycle; returns 1ns into the following cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1 drive(1, op, 0, a, b);
    @(posedge clk); #1 drive(0, 4'd0, 0, 32'd0, 32'd0);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    bit          s, c;

    drive(0, 4'd0, 0, 32'd0, 32'd0);
    reset_n = 1'b0;
    wait_edges(2);
    reset_n = 1'b1;
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", bus.busy, 1'b0);

    // MULT -2 * 3
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy_t1", bus.busy, 1'b1);
    wait_edges(MC);
    check("mult_busy_done", bus.busy, 1'b0);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // DIVU 100 / 7
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_edges(DC - 1);
    check("divu_busy_last", bus.busy, 1'b1);
    wait_edges(1);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    // DIV -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_edges(DC);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    // DIV overflow 0x80000000 / -1
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_edges(DC);
    check("divovf_lo", bus.lo, 32'h8000_0000);
    check("divovf_hi", bus.hi, 32'd0);

    // MTHI/MTLO preload then divide by zero
    issue(MD_MTHI, 32'h11, 32'd0);
    check("mthi_busy", bus.busy, 1'b0);
    check("mthi_hi", bus.hi, 32'h11);
    issue(MD_MTLO, 32'h22, 32'd0);
    check("mtlo_lo", bus.lo, 32'h22);
    issue(MD_DIV, 32'd5, 32'd0);
    check("div0_busy", bus.busy, 1'b1);
    wait_edges(DC);
    check("div0_busy_done", bus.busy, 1'b0);
    check("div0_hi", bus.hi, 32'h11);
    check("div0_lo", bus.lo, 32'h22);

    // MULTU with cancel in the same cycle
    @(posedge clk); #1 drive(1, MD_MULTU, 1, 32'd5, 32'd6);
    #2 check("cancel_stall", bus.md_stall_req, 1'b0);
    @(posedge clk); #1 drive(0, 4'd0, 0, 32'd0, 32'd0);
    check("cancel_busy", bus.busy, 1'b0);
    check("cancel_hi", bus.hi, 32'h11);

    // MULTU accepted, cancel raised at T+2 does not abort
    issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    wait_edges(1);
    bus.cancel = 1'b1;
    wait_edges(MC - 1);
    bus.cancel = 1'b0;
    check("cancelbusy_busy", bus.busy, 1'b0);
    check("cancelbusy_hi", bus.hi, 32'd1);
    check("cancelbusy_lo", bus.lo, 32'd0);

    // Reset in the middle of a DIV
    issue(MD_DIV, 32'd100, 32'd3);
    wait_edges(3);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    #2 reset_n = 1'b1;
    issue(MD_MULT, 32'd6, 32'd7);
    wait_edges(MC);
    check("post_rst_lo", bus.lo, 32'd42);
    check("post_rst_hi", bus.hi, 32'd0);

`ifdef MD_UNIT_MADD_EN
    issue(MD_MTHI, 32'd0, 32'd0);
    issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(MD_MADDU, 32'd1, 32'd1);
    wait_edges(MC);
    check("maddu_hi", bus.hi, 32'd1);
    check("maddu_lo", bus.lo, 32'd0);
`else
    issue(MD_MADDU, 32'd1, 32'd1);
    check("maddu_off_busy", bus.busy, 1'b0);
    check("maddu_off_lo", bus.lo, 32'd42);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      s  = ($urandom_range(0, 2) != 0);
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(1, 8));
      c  = ($urandom_range(0, 5) == 0);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
      if (m_rem > 0 && multi(op)) s = 1'b0;
      drive(s, op, c, a, b);
    end
    @(posedge clk); #1 drive(0, 4'd0, 0, 32'd0, 32'd0);
    wait_edges(DC + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
